// File: rtl/mfp_ahb_master_pkg.sv
// Shared AHB-lite encodings and the address-phase record for the command-driven bus initiator.
package mfp_ahb_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } ap_entry_t;

  // True when the address is naturally aligned for a legal transfer size.
  function automatic logic size_aligned(input logic [31:0] addr, input logic [2:0] size);
    case (size)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return addr[0] == 1'b0;
      HSIZE_WORD: return addr[1:0] == 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mfp_ahb_master_if.sv
// Command/response handshake plus AHB-lite master signals for mfp_ahb_master.
interface mfp_ahb_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/mfp_ahb_master.sv
// AHB-lite initiator: valid/ready commands become single NONSEQ transfers with an
// address-phase / data-phase register pair, wait-state hold and two-cycle ERROR handling.
module mfp_ahb_master
  import mfp_ahb_master_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic             HCLK,
  input  logic             HRESET,
  mfp_ahb_master_if.master bus
);

  ap_entry_t   ap;
  logic        ap_valid;
  logic        ap_cancel;
  logic        dp_valid;
  logic        dp_write;
  logic [31:0] dp_wdata;
  logic        dp_cancel;
  logic        cancel_pend;
  logic        accept;
  logic        first_err;

  assign bus.cmd_ready = !HRESET && !cancel_pend && (!ap_valid || bus.HREADY);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  // First cycle of the two-cycle ERROR response: slave flags error while still stalling.
  assign first_err     = dp_valid && (bus.HRESP == HRESP_ERROR) && !bus.HREADY;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ap_valid  <= 1'b0;
      ap_cancel <= 1'b0;
      ap        <= '{addr: '0, write: 1'b0, size: HSIZE_WORD, wdata: '0};
    end else if (first_err) begin
      // Follow-on transfer is withdrawn from the bus but still owes a response.
      ap_valid  <= 1'b0;
      ap_cancel <= ap_valid || accept;
    end else begin
      if (accept) begin
        ap_valid <= 1'b1;
        ap       <= '{addr: bus.cmd_addr, write: bus.cmd_write,
                      size: bus.cmd_size, wdata: bus.cmd_wdata};
      end else if (bus.HREADY) begin
        ap_valid <= 1'b0;
      end
      if (bus.HREADY) ap_cancel <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_wdata  <= '0;
      dp_cancel <= 1'b0;
    end else begin
      // A cancelled entry lives in the data slot for exactly one cycle.
      dp_cancel <= bus.HREADY && ap_cancel;
      if (bus.HREADY) begin
        dp_valid <= ap_valid;
        dp_write <= ap.write;
        dp_wdata <= ap.wdata;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cancel_pend <= 1'b0;
    end else if (first_err) begin
      cancel_pend <= 1'b1;
    end else if (dp_cancel || (bus.HREADY && !ap_cancel)) begin
      cancel_pend <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      if (dp_cancel) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= 1'b1;
        bus.rsp_rdata <= '0;
      end else if (bus.HREADY && dp_valid) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= bus.HRESP;
        bus.rsp_rdata <= (!dp_write && bus.HRESP == HRESP_OKAY) ? bus.HRDATA : '0;
      end
    end
  end

  assign bus.HTRANS    = ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = ap.addr;
  assign bus.HWRITE    = ap.write;
  assign bus.HSIZE     = ap.size;
  assign bus.HWDATA    = dp_wdata;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = HPROT_VAL;

endmodule
